morph3x3_binary: RTL

- Downstream stage of the binarization block: consumes its 1-bit raster pixel stream and applies a 3x3 morphological erosion or dilation.
- Emits one filtered pixel per input pixel, with its linear frame address, so the result can be written to a frame RAM or display buffer.
- Start is a single control pulse, following the codebase's int_ctrl/bin_ctrl convention; two status LED bits report progress.

---
 rtl/morph3x3_binary_if.sv | 33 +++
 rtl/morph3x3_binary.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/morph3x3_binary_if.sv
`default_nettype none
// ============================================================================
// Module      : morph3x3_binary_if
// Description : Pixel stream bundle for the 3x3 binary morphology stage.
//               master = pixel source / result sink, slave = filter core.
// Revision    : 1.0  initial release
// ============================================================================
interface morph3x3_binary_if #(
    parameter int ADDR_W = 16
);
    logic              pix_valid;
    logic              pix_data;
    logic              out_valid;
    logic [ADDR_W-1:0] out_addr;
    logic              out_data;

    modport master (
        output pix_valid,
        output pix_data,
        input  out_valid,
        input  out_addr,
        input  out_data
    );

    modport slave (
        input  pix_valid,
        input  pix_data,
        output out_valid,
        output out_addr,
        output out_data
    );
endinterface
`default_nettype wire

// File: rtl/morph3x3_binary.sv
`default_nettype none
// ============================================================================
// Module      : morph3x3_binary
// Description : 3x3 binary erosion/dilation on a raster 1-bit pixel stream,
//               zero-padded borders, one output pixel per input pixel with
//               its linear frame address.
//               Optional macro MORPH_FGCOUNT_EN adds the fg_count port that
//               counts foreground (1) output pixels of the current frame.
// Revision    : 1.0  initial release
// ============================================================================
module morph3x3_binary #(
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int ADDR_W = 16
) (
    input  wire logic          morph_clk,
    input  wire logic          morph_rst,
    input  wire logic          morph_ctrl,
    input  wire logic          morph_mode,
    morph3x3_binary_if.slave   px,
    output logic               frame_done,
    output logic [1:0]         condition_led
`ifdef MORPH_FGCOUNT_EN
    ,
    output logic [ADDR_W:0]    fg_count
`endif
);

    localparam int c_SR_W  = 2 * IMG_W + 3;
    localparam int c_COL_W = $clog2(IMG_W);
    localparam int c_ROW_W = $clog2(IMG_H);

    localparam logic [ADDR_W-1:0]  c_FILL_END = ADDR_W'(IMG_W + 1);
    localparam logic [ADDR_W-1:0]  c_LAST     = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(IMG_W - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(IMG_H - 1);

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_FILL  = 3'd1;
    localparam logic [2:0] c_S_RUN   = 3'd2;
    localparam logic [2:0] c_S_FLUSH = 3'd3;
    localparam logic [2:0] c_S_DONE  = 3'd4;

    logic [2:0]        r_state;
    logic [1:0]        r_led;
    logic              r_frame_done;
    logic              r_mode;
    logic              r_ctrl_d;
    logic [ADDR_W-1:0] r_in_cnt;
    logic [ADDR_W-1:0] r_out_cnt;
    logic [c_COL_W-1:0] r_col;
    logic [c_ROW_W-1:0] r_row;
    logic [c_SR_W-1:0] r_sr;
    logic              r_out_valid;
    logic [ADDR_W-1:0] r_out_addr;
    logic              r_out_data;

    logic       w_start;
    logic       w_shift;
    logic       w_shift_bit;
    logic       w_emit;
    logic       w_left;
    logic       w_right;
    logic       w_top;
    logic       w_bot;
    logic [8:0] w_win;
    logic       w_res;

    assign w_start     = (r_state == c_S_IDLE) && morph_ctrl && !r_ctrl_d;
    assign w_shift     = (((r_state == c_S_FILL) || (r_state == c_S_RUN)) && px.pix_valid)
                         || (r_state == c_S_FLUSH);
    assign w_shift_bit = (r_state == c_S_FLUSH) ? 1'b0 : px.pix_data;
    assign w_emit      = ((r_state == c_S_RUN) && px.pix_valid) || (r_state == c_S_FLUSH);

    assign w_left  = (r_col == '0);
    assign w_right = (r_col == c_COL_LAST);
    assign w_top   = (r_row == '0);
    assign w_bot   = (r_row == c_ROW_LAST);

    // Window taps for the current centre; SR[0] is the newest pixel, i.e. the
    // bottom-right neighbour. Taps outside the frame are forced to zero.
    always_comb begin
        w_win    = '0;
        w_win[0] = r_sr[0]           & ~w_right & ~w_bot;
        w_win[1] = r_sr[1]                      & ~w_bot;
        w_win[2] = r_sr[2]           & ~w_left  & ~w_bot;
        w_win[3] = r_sr[IMG_W]       & ~w_right;
        w_win[4] = r_sr[IMG_W+1];
        w_win[5] = r_sr[IMG_W+2]     & ~w_left;
        w_win[6] = r_sr[2*IMG_W]     & ~w_right & ~w_top;
        w_win[7] = r_sr[2*IMG_W+1]              & ~w_top;
        w_win[8] = r_sr[2*IMG_W+2]   & ~w_left  & ~w_top;
        w_res    = r_mode ? (|w_win) : (&w_win);
    end

    // Frame sequencing: start detection, input counting, status LED, done pulse.
    always_ff @(posedge morph_clk) begin
        if (morph_rst) begin
            r_state      <= c_S_IDLE;
            r_led        <= 2'b00;
            r_frame_done <= 1'b0;
            r_mode       <= 1'b0;
            r_ctrl_d     <= 1'b0;
            r_in_cnt     <= '0;
        end else begin
            r_ctrl_d     <= morph_ctrl;
            r_frame_done <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (w_start) begin
                        r_mode   <= morph_mode;
                        r_in_cnt <= '0;
                        r_state  <= c_S_FILL;
                        r_led    <= 2'b01;
                    end
                end
                c_S_FILL: begin
                    if (px.pix_valid) begin
                        r_in_cnt <= r_in_cnt + 1'b1;
                        // Shifting pixel IMG_W+1 completes the window of pixel 0.
                        if (r_in_cnt == c_FILL_END) begin
                            r_state <= c_S_RUN;
                            r_led   <= 2'b10;
                        end
                    end
                end
                c_S_RUN: begin
                    if (px.pix_valid) begin
                        r_in_cnt <= r_in_cnt + 1'b1;
                        if (r_in_cnt == c_LAST) begin
                            r_state <= c_S_FLUSH;
                        end
                    end
                end
                c_S_FLUSH: begin
                    if (r_out_cnt == c_LAST) begin
                        r_state <= c_S_DONE;
                        r_led   <= 2'b11;
                    end
                end
                c_S_DONE: begin
                    r_frame_done <= 1'b1;
                    r_state      <= c_S_IDLE;
                    r_led        <= 2'b00;
                end
                default: begin
                    r_state <= c_S_IDLE;
                    r_led   <= 2'b00;
                end
            endcase
        end
    end

`ifdef MORPH_FGCOUNT_EN
    logic [ADDR_W:0] r_fg_count;

    // Foreground tally of emitted pixels; held after the frame until next start.
    always_ff @(posedge morph_clk) begin
        if (morph_rst || w_start) begin
            r_fg_count <= '0;
        end else if (w_emit && w_res) begin
            r_fg_count <= r_fg_count + 1'b1;
        end
    end

    assign fg_count = r_fg_count;
`endif

    // Window shift register, centre row/column tracking and registered outputs.
    always_ff @(posedge morph_clk) begin
        if (morph_rst) begin
            r_sr        <= '0;
            r_out_cnt   <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_out_valid <= 1'b0;
            r_out_addr  <= '0;
            r_out_data  <= 1'b0;
        end else begin
            r_out_valid <= w_emit;
            if (w_start) begin
                r_sr      <= '0;
                r_out_cnt <= '0;
                r_col     <= '0;
                r_row     <= '0;
            end else begin
                if (w_shift) begin
                    r_sr <= {r_sr[c_SR_W-2:0], w_shift_bit};
                end
                if (w_emit) begin
                    r_out_addr <= r_out_cnt;
                    r_out_data <= w_res;
                    r_out_cnt  <= r_out_cnt + 1'b1;
                    if (r_col == c_COL_LAST) begin
                        r_col <= '0;
                        r_row <= r_row + 1'b1;
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                end
            end
        end
    end

    assign px.out_valid  = r_out_valid;
    assign px.out_addr   = r_out_addr;
    assign px.out_data   = r_out_data;
    assign frame_done    = r_frame_done;
    assign condition_led = r_led;

endmodule
`default_nettype wire
